// File: rtl/analog_input_emu_if.sv
// Input-emulator bus between the game input logic (master) and analog_input_emu (slave).
// Macro ANALOG_INPUT_DEADZONE_EN (used by analog_input_emu) does not affect this interface.
//   strobe : update strobe (vsync). The emulator acts on its rising edge.
//   mode   : 2 bits per channel. Channel i uses bits [2i+1:2i].
//   plus   : per-channel increment button.
//   minus  : per-channel decrement button.
//   analog : signed 8-bit stick value per channel. Channel i uses bits [8i+7:8i].
//   value  : per-channel position. Channel i uses bits [WIDTH*(i+1)-1:WIDTH*i].
//   valid  : one-cycle pulse on each update.
interface analog_input_emu_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
);
  logic                      strobe;
  logic [2*CHANNELS-1:0]     mode;
  logic [CHANNELS-1:0]       plus;
  logic [CHANNELS-1:0]       minus;
  logic [8*CHANNELS-1:0]     analog;
  logic [WIDTH*CHANNELS-1:0] value;
  logic                      valid;

  modport master (
    output strobe, mode, plus, minus, analog,
    input  value, valid
  );

  modport slave (
    input  strobe, mode, plus, minus, analog,
    output value, valid
  );
endinterface

// File: rtl/analog_input_emu.sv
// Multi-channel steering/pedal/spinner/analog input emulator.
// Each channel turns plus/minus buttons or a signed stick value into a position value.
// A channel is updated once per rising edge of bus.strobe.
// Optional macro ANALOG_INPUT_DEADZONE_EN enables a rescaled deadzone on the analog mode.
// Ports:
//   clk     : system clock.
//   reset_n : synchronous, active-low reset.
//   bus     : analog_input_emu_if slave. It carries strobe, mode, plus, minus and analog in,
//             and value and valid out.
// Modes: 0 = self-centering, 1 = hold, 2 = wrapping spinner, 3 = analog passthrough.
module analog_input_emu #(
  parameter int unsigned      CHANNELS    = 2,
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] CENTER      = WIDTH'(8'h80),
  parameter logic [WIDTH-1:0] VMIN        = WIDTH'(8'h10),
  parameter logic [WIDTH-1:0] VMAX        = WIDTH'(8'hF0),
  parameter int unsigned      MAX_STEP    = 4,
  parameter int unsigned      RETURN_STEP = 2,
  parameter int unsigned      DEADZONE    = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  analog_input_emu_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_CENTER = 2'd0,
    MODE_HOLD   = 2'd1,
    MODE_SPIN   = 2'd2,
    MODE_ANALOG = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DN   = 2'd2
  } dir_t;

`ifdef ANALOG_INPUT_DEADZONE_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  // Two guard bits so that sums, differences and analog offsets never wrap before clamping.
  localparam int unsigned EW     = WIDTH + 2;
  localparam int unsigned STEP_W = $clog2(MAX_STEP + 1);

  localparam logic [STEP_W-1:0]  STEP_ONE   = STEP_W'(1);
  localparam logic [STEP_W-1:0]  STEP_MAX   = STEP_W'(MAX_STEP);
  localparam logic signed [EW-1:0] CENTER_S = $signed(EW'(CENTER));
  localparam logic signed [EW-1:0] VMIN_S   = $signed(EW'(VMIN));
  localparam logic signed [EW-1:0] VMAX_S   = $signed(EW'(VMAX));
  localparam logic signed [EW-1:0] RET_S    = $signed(EW'(RETURN_STEP));
  localparam logic signed [EW-1:0] TOP_S    = $signed(EW'({WIDTH{1'b1}}));
  localparam logic signed [9:0]    DZ_S     = $signed(10'(DEADZONE));

  logic                  strobe_d;
  logic                  valid_q;
  logic                  tick_c;
  logic [2*CHANNELS-1:0] prev_mode_q;
  logic [WIDTH-1:0]      value_q [CHANNELS];
  logic [WIDTH-1:0]      value_n [CHANNELS];
  logic [STEP_W-1:0]     step_q  [CHANNELS];
  logic [STEP_W-1:0]     step_n  [CHANNELS];
  dir_t                  dir_q   [CHANNELS];
  dir_t                  dir_n   [CHANNELS];

  assign tick_c = bus.strobe & ~strobe_d;

  // State registers. Reset takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      strobe_d    <= 1'b0;
      valid_q     <= 1'b0;
      prev_mode_q <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        value_q[i] <= CENTER;
        step_q[i]  <= STEP_ONE;
        dir_q[i]   <= DIR_NONE;
      end
    end else begin
      strobe_d <= bus.strobe;
      valid_q  <= tick_c;
      if (tick_c) prev_mode_q <= bus.mode;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        value_q[i] <= value_n[i];
        step_q[i]  <= step_n[i];
        dir_q[i]   <= dir_n[i];
      end
    end
  end

  // Per-channel next state. Nothing changes except on a tick.
  always_comb begin
    mode_t                 ch_mode;
    dir_t                  dir_c;
    logic [STEP_W-1:0]     step_c;
    logic signed [EW-1:0]  cur_s;
    logic signed [EW-1:0]  stp_s;
    logic signed [EW-1:0]  up_s;
    logic signed [EW-1:0]  dn_s;
    logic signed [EW-1:0]  ret_s;
    logic signed [EW-1:0]  an_s;
    logic signed [9:0]     a_s;
    logic signed [9:0]     a_e;
    logic [WIDTH-1:0]      an_v;

    for (int i = 0; i < int'(CHANNELS); i++) begin
      value_n[i] = value_q[i];
      step_n[i]  = step_q[i];
      dir_n[i]   = dir_q[i];

      ch_mode = mode_t'(bus.mode[2*i +: 2]);

      if (bus.plus[i] && !bus.minus[i])      dir_c = DIR_UP;
      else if (bus.minus[i] && !bus.plus[i]) dir_c = DIR_DN;
      else                                   dir_c = DIR_NONE;

      // Acceleration: the step grows while the same direction is held.
      // The step computed here is the one applied on this tick.
      if (dir_c != DIR_NONE && dir_c == dir_q[i])
        step_c = (step_q[i] >= STEP_MAX) ? STEP_MAX : step_q[i] + STEP_ONE;
      else
        step_c = STEP_ONE;

      cur_s = $signed(EW'(value_q[i]));
      stp_s = $signed(EW'(step_c));
      up_s  = cur_s + stp_s;
      dn_s  = cur_s - stp_s;

      // Return toward CENTER without overshooting it.
      if (cur_s > CENTER_S)
        ret_s = (cur_s - RET_S < CENTER_S) ? CENTER_S : cur_s - RET_S;
      else if (cur_s < CENTER_S)
        ret_s = (cur_s + RET_S > CENTER_S) ? CENTER_S : cur_s + RET_S;
      else
        ret_s = CENTER_S;

      // Analog value: optional deadzone with rescale, then scale to WIDTH, offset and clamp.
      a_s = 10'($signed(bus.analog[8*i +: 8]));
      if (DZ_EN && a_s <= DZ_S && a_s >= -DZ_S) a_e = 10'sd0;
      else if (DZ_EN && a_s > 10'sd0)           a_e = a_s - DZ_S;
      else if (DZ_EN)                           a_e = a_s + DZ_S;
      else                                      a_e = a_s;
      an_s = EW'(a_e);
      an_s = CENTER_S + (an_s <<< (WIDTH - 8));
      if (an_s < $signed(EW'(0)))  an_v = '0;
      else if (an_s > TOP_S)       an_v = {WIDTH{1'b1}};
      else                         an_v = WIDTH'(an_s);

      if (tick_c) begin
        if (bus.mode[2*i +: 2] != prev_mode_q[2*i +: 2]) begin
          value_n[i] = CENTER;
          step_n[i]  = STEP_ONE;
          dir_n[i]   = DIR_NONE;
        end else begin
          case (ch_mode)
            MODE_ANALOG: begin
              value_n[i] = an_v;
              step_n[i]  = STEP_ONE;
              dir_n[i]   = DIR_NONE;
            end
            MODE_SPIN: begin
              step_n[i] = step_c;
              dir_n[i]  = dir_c;
              if (dir_c == DIR_UP)      value_n[i] = value_q[i] + WIDTH'(step_c);
              else if (dir_c == DIR_DN) value_n[i] = value_q[i] - WIDTH'(step_c);
            end
            default: begin
              step_n[i] = step_c;
              dir_n[i]  = dir_c;
              if (dir_c == DIR_UP)
                value_n[i] = (up_s > VMAX_S) ? VMAX : WIDTH'(up_s);
              else if (dir_c == DIR_DN)
                value_n[i] = (dn_s < VMIN_S) ? VMIN : WIDTH'(dn_s);
              else if (ch_mode == MODE_CENTER)
                value_n[i] = WIDTH'(ret_s);
            end
          endcase
        end
      end
    end
  end

  // Flatten the per-channel registers onto the bus.
  for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_out
    assign bus.value[WIDTH*g +: WIDTH] = value_q[g];
  end

  assign bus.valid = valid_q;

endmodule

// File: tb/tb_analog_input_emu.sv
// Directed self-checking bench for analog_input_emu (2 channels, 8-bit values).
// When ANALOG_INPUT_DEADZONE_EN is defined, the expected values for the analog deadzone follow it.
module tb_analog_input_emu;
  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  analog_input_emu_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  analog_input_emu #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [W-1:0] v(input int ch);
    return bus.value[W*ch +: W];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobe pulse. The task returns on the falling edge after the update edge.
  task automatic tick();
    @(negedge clk);
    bus.strobe = 1'b1;
    @(negedge clk);
    bus.strobe = 1'b0;
  endtask

  task automatic tick_chk(input string tag, input int ch, input logic [7:0] exp);
    tick();
    chk(tag, 32'(v(ch)), 32'(exp));
  endtask

  int pulses;
  logic first_valid;

  initial begin
    bus.strobe = 1'b0;
    bus.mode   = '0;
    bus.plus   = '0;
    bus.minus  = '0;
    bus.analog = '0;
    reset_n    = 1'b0;
    repeat (2) @(negedge clk);

    // A strobe edge while reset is asserted must not update anything.
    bus.strobe = 1'b1;
    @(negedge clk);
    chk("rst_edge_valid", 32'(bus.valid), 32'd0);
    chk("rst_edge_v0", 32'(v(0)), 32'h80);
    bus.strobe = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_v0", 32'(v(0)), 32'h80);
    chk("rst_v1", 32'(v(1)), 32'h80);
    chk("rst_valid", 32'(bus.valid), 32'd0);

    // Mode 0: acceleration, then return to center.
    bus.plus = 2'b01;
    tick_chk("m0_acc1", 0, 8'h81);
    chk("valid_pulse", 32'(bus.valid), 32'd1);
    @(negedge clk);
    chk("valid_drop", 32'(bus.valid), 32'd0);
    tick_chk("m0_acc2", 0, 8'h83);
    tick_chk("m0_acc3", 0, 8'h86);
    tick_chk("m0_acc4", 0, 8'h8A);
    tick_chk("m0_acc5", 0, 8'h8E);
    chk("m0_ch1_idle", 32'(v(1)), 32'h80);
    bus.plus = 2'b00;
    tick_chk("m0_ret1", 0, 8'h8C);
    tick_chk("m0_ret2", 0, 8'h8A);
    tick_chk("m0_ret3", 0, 8'h88);
    tick_chk("m0_ret4", 0, 8'h86);
    tick_chk("m0_ret5", 0, 8'h84);
    tick_chk("m0_ret6", 0, 8'h82);
    tick_chk("m0_ret7", 0, 8'h80);
    tick_chk("m0_rest", 0, 8'h80);

    // Mode 0: clamp at VMAX.
    bus.plus = 2'b01;
    repeat (28) tick();
    tick_chk("m0_run_ee", 0, 8'hEE);
    tick_chk("m0_run_clamp", 0, 8'hF0);
    bus.plus = 2'b00;
    tick_chk("m0_back_ee", 0, 8'hEE);
    bus.plus = 2'b01;
    tick_chk("m0_clamp1", 0, 8'hEF);
    tick_chk("m0_clamp2", 0, 8'hF0);
    tick_chk("m0_clamp3", 0, 8'hF0);

    // Mode 1: hold.
    bus.plus = 2'b00;
    bus.mode = 4'b0001;
    tick_chk("m1_switch", 0, 8'h80);
    bus.minus = 2'b01;
    tick_chk("m1_dn1", 0, 8'h7F);
    tick_chk("m1_dn2", 0, 8'h7D);
    tick_chk("m1_dn3", 0, 8'h7A);
    bus.minus = 2'b00;
    repeat (3) tick();
    tick_chk("m1_hold", 0, 8'h7A);
    bus.plus  = 2'b01;
    bus.minus = 2'b01;
    tick_chk("m1_both", 0, 8'h7A);
    bus.plus  = 2'b00;
    tick_chk("m1_step_reset", 0, 8'h79);

    // Mode 2: wrapping spinner.
    bus.minus = 2'b00;
    bus.mode  = 4'b0010;
    tick_chk("m2_switch", 0, 8'h80);
    bus.plus = 2'b01;
    repeat (32) tick();
    tick_chk("m2_run_fe", 0, 8'hFE);
    bus.plus = 2'b00;
    tick_chk("m2_hold", 0, 8'hFE);
    bus.plus = 2'b01;
    tick_chk("m2_up1", 0, 8'hFF);
    tick_chk("m2_wrap", 0, 8'h01);
    tick_chk("m2_up3", 0, 8'h04);
    // Reversal on ch0 while ch1 (mode 0) moves up on the same tick.
    bus.plus  = 2'b10;
    bus.minus = 2'b01;
    tick();
    chk("m2_reverse", 32'(v(0)), 32'h03);
    chk("par_ch1", 32'(v(1)), 32'h81);
    chk("par_valid", 32'(bus.valid), 32'd1);

    // Mode 3 on ch1. plus[1] stays pressed and must be ignored.
    bus.minus = 2'b00;
    bus.mode  = 4'b1110;
    bus.analog = {8'h40, 8'h00};
    tick_chk("m3_switch", 1, 8'h80);
    tick_chk("m3_pos40", 1, 8'hC0);
    bus.analog = {8'h80, 8'h00};
    tick_chk("m3_min", 1, 8'h00);
    bus.analog = {8'h7F, 8'h00};
    tick_chk("m3_max", 1, 8'hFF);
`ifdef ANALOG_INPUT_DEADZONE_EN
    bus.analog = {8'h05, 8'h00};
    tick_chk("m3_dz_in", 1, 8'h80);
    bus.analog = {8'h10, 8'h00};
    tick_chk("m3_dz_out", 1, 8'h88);
`else
    bus.analog = {8'h05, 8'h00};
    tick_chk("m3_raw05", 1, 8'h85);
    bus.analog = {8'h10, 8'h00};
    tick_chk("m3_raw10", 1, 8'h90);
`endif
    chk("m3_ch0_hold", 32'(v(0)), 32'h03);
    bus.mode = 4'b0010;
    tick_chk("m3_to_m0", 1, 8'h80);
    tick_chk("m0_after_m3", 1, 8'h81);

    // Strobe held high for 10 clocks produces a single update.
    bus.plus = 2'b00;
    @(negedge clk);
    bus.strobe  = 1'b1;
    pulses      = 0;
    first_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) first_valid = bus.valid;
      if (bus.valid) pulses++;
    end
    bus.strobe = 1'b0;
    chk("strobe_first", 32'(first_valid), 32'd1);
    chk("strobe_pulses", 32'(pulses), 32'd1);
    chk("strobe_ch1_ret", 32'(v(1)), 32'h80);
    chk("strobe_ch0", 32'(v(0)), 32'h03);
    @(negedge clk);
    chk("strobe_low_valid", 32'(bus.valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
